// File: rtl/scratch_pad_read_sequencer.sv
// scratch_pad_read_sequencer: streams one layer's rows to the scratch-pad read port and
// tracks BRAM read latency to flag returned rows as valid/last.
module scratch_pad_read_sequencer #(
   parameter int ADDR_W  = 3,
   parameter int LAYER_W = 3,
   parameter int RD_LAT  = 1,
   parameter int CNT_W   = 4
) (
   input  logic               read_clk,
   input  logic               rst,
   input  logic               start,
   input  logic [LAYER_W-1:0] layer,
   input  logic [CNT_W-1:0]   num_rows,
   input  logic [CNT_W-1:0]   num_rep,
   input  logic               stall,
   output logic               rd_en,
   output logic [ADDR_W-1:0]  rd_addr,
   output logic               data_valid,
   output logic               data_last,
   output logic               busy,
   output logic               done
);
   localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2, FIN = 2'd3;
   logic [1:0]        state;
   logic [CNT_W-1:0]  rows, reps, row_idx, pass;
   logic [ADDR_W-1:0] base, start_base;
   logic [RD_LAT-1:0] pv, pl;
   logic [RD_LAT:0]   vs, ls;
   logic              row_end, is_last, pipe_next_empty;
   assign start_base = ADDR_W'({layer, 1'b0});
   assign rd_en      = (state == ISSUE) & ~stall;
   assign row_end    = row_idx == rows - CNT_W'(1);
   assign is_last    = row_end & (pass == reps - CNT_W'(1));
   assign vs         = {pv, rd_en};
   assign ls         = {pl, rd_en & is_last};
   assign data_valid = pv[RD_LAT-1] & ~stall;
   assign data_last  = data_valid & pl[RD_LAT-1];
   // FIN is entered on the edge that retires the final row, so done follows data_last directly
   assign pipe_next_empty = stall ? ~|pv : ~|vs[RD_LAT-1:0];
   assign busy = state != IDLE;
   assign done = state == FIN;
   always_ff @(posedge read_clk) begin
      if (rst) begin
         state   <= IDLE;
         rd_addr <= '0;
         base    <= '0;
         pv      <= '0;
         pl      <= '0;
         rows    <= '0;
         reps    <= '0;
         row_idx <= '0;
         pass    <= '0;
      end else begin
         if (!stall) begin
            pv <= vs[RD_LAT-1:0];
            pl <= ls[RD_LAT-1:0];
         end
         case (state)
            IDLE: if (start) begin
               rows    <= num_rows;
               reps    <= (num_rep == '0) ? CNT_W'(1) : num_rep;
               base    <= start_base;
               rd_addr <= start_base;
               row_idx <= '0;
               pass    <= '0;
               state   <= (num_rows == '0) ? FIN : ISSUE;
            end
            ISSUE: if (rd_en) begin
               row_idx <= row_end ? '0 : row_idx + CNT_W'(1);
               pass    <= row_end ? pass + CNT_W'(1) : pass;
               rd_addr <= row_end ? base : rd_addr + ADDR_W'(1);
               state   <= is_last ? DRAIN : ISSUE;
            end
            DRAIN: state <= pipe_next_empty ? FIN : DRAIN;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_scratch_pad_read_sequencer.sv
// tb_scratch_pad_read_sequencer: queue-based reference model plus directed jobs with
// hand-computed address/timing expectations.
module tb_scratch_pad_read_sequencer;
   localparam int AW = 3, LW = 3, LAT = 1, CW = 4;
   logic          read_clk = 0, rst = 1, start = 0, stall = 0;
   logic [LW-1:0] layer = '0;
   logic [CW-1:0] num_rows = '0, num_rep = '0;
   logic          rd_en, data_valid, data_last, busy, done;
   logic [AW-1:0] rd_addr;

   scratch_pad_read_sequencer #(.ADDR_W(AW), .LAYER_W(LW), .RD_LAT(LAT), .CNT_W(CW)) dut (
      .read_clk(read_clk), .rst(rst), .start(start), .layer(layer), .num_rows(num_rows),
      .num_rep(num_rep), .stall(stall), .rd_en(rd_en), .rd_addr(rd_addr),
      .data_valid(data_valid), .data_last(data_last), .busy(busy), .done(done));

   always #5 read_clk = ~read_clk;

   int vectors = 0, miscompares = 0;
   int cyc = 0, t0 = 0;
   bit chk_en = 0;

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
      end
   endtask

   // reference model: rows still to issue, rows in flight with remaining latency
   typedef struct { int addr; bit last; } req_t;
   typedef struct { int ticks; bit last; } fly_t;
   req_t pend[$];
   fly_t fly[$];
   int   m_phase = 0, old_phase, m_reps;

   always @(posedge read_clk) begin
      cyc <= cyc + 1;
      old_phase = m_phase;
      if (rst) begin
         m_phase = 0;
         pend.delete();
         fly.delete();
      end else begin
         if (!stall) begin
            if (fly.size() > 0 && fly[0].ticks == 0) void'(fly.pop_front());
            foreach (fly[i]) fly[i].ticks--;
            if (old_phase == 1) begin
               fly.push_back('{LAT - 1, pend[0].last});
               void'(pend.pop_front());
               if (pend.size() == 0) m_phase = 2;
            end else if (old_phase == 2 && fly.size() == 0) m_phase = 3;
         end
         if (old_phase == 3) m_phase = 0;
         if (old_phase == 0 && start) begin
            m_reps = (num_rep == 0) ? 1 : int'(num_rep);
            for (int p = 0; p < m_reps; p++)
               for (int r = 0; r < int'(num_rows); r++)
                  pend.push_back('{(2 * int'(layer) + r) % (2 ** AW),
                                   (p == m_reps - 1) && (r == int'(num_rows) - 1)});
            m_phase = (num_rows == 0) ? 3 : 1;
         end
      end
   end

   // observation log used by the directed checks
   int addr_log[$];
   int valid_cnt, last_cnt, done_cnt, first_en, first_v, last_cyc, last_idx, done_cyc;
   bit e_v;

   task automatic clear_log();
      addr_log.delete();
      valid_cnt = 0; last_cnt = 0; done_cnt = 0;
      first_en = -1; first_v = -1; last_cyc = -1; last_idx = -1; done_cyc = -1;
   endtask

   always @(negedge read_clk) begin
      if (chk_en) begin
         e_v = fly.size() > 0 && fly[0].ticks == 0 && !stall;
         chk("rd_en", rd_en, m_phase == 1 && !stall);
         if (m_phase == 1) chk("rd_addr", rd_addr, pend[0].addr);
         chk("data_valid", data_valid, e_v);
         chk("data_last", data_last, e_v && fly[0].last);
         chk("busy", busy, m_phase != 0);
         chk("done", done, m_phase == 3);
         if (rd_en) begin
            addr_log.push_back(int'(rd_addr));
            if (first_en < 0) first_en = cyc;
         end
         if (data_valid) begin
            valid_cnt++;
            if (first_v < 0) first_v = cyc;
            if (data_last) begin last_cyc = cyc; last_idx = valid_cnt; last_cnt++; end
         end
         if (done) begin done_cyc = cyc; done_cnt++; end
      end
   end

   task automatic start_job(input int l, input int r, input int p);
      clear_log();
      @(posedge read_clk); #1;
      layer = LW'(l); num_rows = CW'(r); num_rep = CW'(p); start = 1; t0 = cyc;
      @(posedge read_clk); #1;
      start = 0;
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      while (n < budget) begin
         @(negedge read_clk);
         if (done) break;
         n++;
      end
      if (n == budget) chk("done_timeout", 0, 1);
      @(posedge read_clk); #1;
   endtask

   task automatic chk_addrs(input string name, input int exp[]);
      chk({name, "_count"}, addr_log.size(), exp.size());
      foreach (exp[i]) if (i < addr_log.size()) chk(name, addr_log[i], exp[i]);
   endtask

   initial begin
      clear_log();
      @(posedge read_clk); #1;
      chk_en = 1;
      repeat (2) @(posedge read_clk);
      #1 rst = 0;
      @(negedge read_clk);
      chk("reset_rd_en", rd_en, 0);
      chk("reset_rd_addr", rd_addr, 0);
      chk("reset_valid", data_valid, 0);
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);

      start_job(1, 3, 1);
      wait_done(30);
      chk_addrs("t1_addr", '{2, 3, 4});
      chk("t1_first_en", first_en, t0 + 1);
      chk("t1_first_valid", first_v, t0 + 2);
      chk("t1_last_cyc", last_cyc, t0 + 4);
      chk("t1_done_cyc", done_cyc, t0 + 5);
      chk("t1_valids", valid_cnt, 3);

      start_job(3, 4, 0);
      wait_done(30);
      chk_addrs("t2_addr", '{6, 7, 0, 1});
      chk("t2_valids", valid_cnt, 4);
      chk("t2_dones", done_cnt, 1);

      start_job(0, 2, 3);
      wait_done(40);
      chk_addrs("t3_addr", '{0, 1, 0, 1, 0, 1});
      chk("t3_last_idx", last_idx, 6);
      chk("t3_last_cnt", last_cnt, 1);

      start_job(2, 4, 1);
      @(posedge read_clk); #1 stall = 1;
      repeat (2) @(posedge read_clk);
      #1 stall = 0;
      wait_done(30);
      chk_addrs("t4_addr", '{4, 5, 6, 7});
      chk("t4_valids", valid_cnt, 4);
      chk("t4_last_cnt", last_cnt, 1);

      start_job(2, 0, 1);
      wait_done(10);
      chk("t5_done_cyc", done_cyc, t0 + 1);
      chk("t5_rd_en_cnt", addr_log.size(), 0);
      chk("t5_valids", valid_cnt, 0);

      start_job(1, 3, 1);
      start = 1; layer = 3'd5; num_rows = 4'd2;
      @(posedge read_clk); #1 start = 0;
      wait_done(30);
      chk_addrs("t6_addr", '{2, 3, 4});
      chk("t6_dones", done_cnt, 1);

      start_job(0, 5, 1);
      @(posedge read_clk); #1 rst = 1;
      @(posedge read_clk); #1 rst = 0;
      @(negedge read_clk);
      chk("t7_rd_en", rd_en, 0);
      chk("t7_rd_addr", rd_addr, 0);
      chk("t7_valid", data_valid, 0);
      chk("t7_busy", busy, 0);
      chk("t7_done", done, 0);
      repeat (8) @(posedge read_clk);
      #1 chk("t7_no_done", done_cnt, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
